// File: rtl/pipeline_pkg.sv
// Shared constants for the elastic pipeline slice: default geometry and the
// width of the delivered-word counter.
package pipeline_pkg;
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned XFER_W    = 32;
endpackage

// File: rtl/pipe_stage.sv
// One elastic register stage: valid/data register plus its accept/advance logic.
// in_ready is combinational from out_ready so a full pipeline can stream.
module pipe_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid;
  logic [WIDTH-1:0] data;
  logic             advance;

  // flush blocks every transfer, so both directions are gated here
  assign advance  = valid && out_ready && !flush;
  assign in_ready = (!valid || advance) && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
    end else if (in_ready) begin
      valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      data <= in_data;
    end
  end

  assign out_valid = valid;
  assign out_data  = data;

endmodule

// File: rtl/elastic_pipeline.sv
// Elastic pipeline of DEPTH pipe_stage registers with valid/ack handshakes,
// occupancy tracking, flush, and a saturating delivered-word counter.
module elastic_pipeline
  import pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DIR,
  input  logic [WIDTH-1:0]  data_in,
  output logic              ack_from_pipeline,
  output logic              DOR,
  output logic [WIDTH-1:0]  data_out,
  input  logic              ack_to_pipeline,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic [XFER_W-1:0] xfer_count
);

  logic in_xfer;
  logic out_xfer;

  // Ready chain runs back from the output stage; each stage keeps its own
  // signals so the chain has no self-dependent vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             rdy;
    logic             vld;
    logic [WIDTH-1:0] dat;
    logic             up_vld;
    logic [WIDTH-1:0] up_dat;
    logic             down_rdy;

    if (i == 0) begin : g_head
      assign up_vld = DIR;
      assign up_dat = data_in;
    end else begin : g_body
      assign up_vld = g_stage[i-1].vld;
      assign up_dat = g_stage[i-1].dat;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign down_rdy = ack_to_pipeline;
    end else begin : g_link
      assign down_rdy = g_stage[i+1].rdy;
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (up_vld),
      .in_data  (up_dat),
      .in_ready (rdy),
      .out_ready(down_rdy),
      .out_valid(vld),
      .out_data (dat)
    );
  end

  assign ack_from_pipeline = g_stage[0].rdy;
  assign DOR               = g_stage[DEPTH-1].vld && !flush;
  assign data_out          = g_stage[DEPTH-1].dat;

  assign in_xfer  = DIR && ack_from_pipeline;
  assign out_xfer = DOR && ack_to_pipeline;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count <= '0;
    end else if (out_xfer && (xfer_count != '1)) begin
      xfer_count <= xfer_count + XFER_W'(1);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: directed scenarios on a DEPTH=2 instance, then
// random handshakes on DEPTH=1 and DEPTH=5 against a word/position queue model.
module tb_elastic_pipeline;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total;
  int unsigned bad;

  // DEPTH=2 instance for directed scenarios
  logic        rst2, dir2, ack2, fl2, af2, dor2, emp2, ful2;
  logic [31:0] din2, dout2, xc2;
  logic [1:0]  cnt2;

  elastic_pipeline #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(rst2), .DIR(dir2), .data_in(din2),
    .ack_from_pipeline(af2), .DOR(dor2), .data_out(dout2),
    .ack_to_pipeline(ack2), .flush(fl2), .count(cnt2),
    .empty(emp2), .full(ful2), .xfer_count(xc2)
  );

  // DEPTH=1 (index 0) and DEPTH=5 (index 1) instances for random stimulus
  logic        r_rst;
  logic        rdir [2];
  logic        rack [2];
  logic        rfl  [2];
  logic [31:0] rdin [2];
  logic        raf  [2];
  logic        rdor [2];
  logic        remp [2];
  logic        rful [2];
  logic [31:0] rdout[2];
  logic [31:0] rxc  [2];
  logic [0:0]  cnt1;
  logic [2:0]  cnt5;

  elastic_pipeline #(.WIDTH(32), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(r_rst), .DIR(rdir[0]), .data_in(rdin[0]),
    .ack_from_pipeline(raf[0]), .DOR(rdor[0]), .data_out(rdout[0]),
    .ack_to_pipeline(rack[0]), .flush(rfl[0]), .count(cnt1),
    .empty(remp[0]), .full(rful[0]), .xfer_count(rxc[0])
  );

  elastic_pipeline #(.WIDTH(32), .DEPTH(5)) u_d5 (
    .clk(clk), .reset(r_rst), .DIR(rdir[1]), .data_in(rdin[1]),
    .ack_from_pipeline(raf[1]), .DOR(rdor[1]), .data_out(rdout[1]),
    .ack_to_pipeline(rack[1]), .flush(rfl[1]), .count(cnt5),
    .empty(remp[1]), .full(rful[1]), .xfer_count(rxc[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of held words, each with its stage position.
  logic [31:0] mdat [2][5];
  int          mpos [2][5];
  int unsigned mocc [2];
  logic [31:0] mxc  [2];
  int          dep  [2];
  logic        in_x [2];
  logic        out_x[2];

  initial begin
    total = 0;
    bad   = 0;
    dep[0] = 1;
    dep[1] = 5;
    rst2 = 1'b1; dir2 = 1'b0; din2 = '0; ack2 = 1'b0; fl2 = 1'b0;
    r_rst = 1'b1;
    for (int unsigned m = 0; m < 2; m++) begin
      rdir[m] = 1'b0; rack[m] = 1'b0; rfl[m] = 1'b0; rdin[m] = '0;
    end

    // reset state
    tick; tick;
    rst2 = 1'b0;
    #1;
    check("rst_count", 32'(cnt2), 32'd0);
    check("rst_empty", 32'(emp2), 32'd1);
    check("rst_full",  32'(ful2), 32'd0);
    check("rst_ack",   32'(af2),  32'd1);
    check("rst_dor",   32'(dor2), 32'd0);
    check("rst_xfer",  xc2,       32'd0);

    // single word, two-edge latency
    dir2 = 1'b1; din2 = 32'h11; ack2 = 1'b1;
    #1 check("single_ack", 32'(af2), 32'd1);
    tick; dir2 = 1'b0;
    #1 check("single_dor_early", 32'(dor2), 32'd0);
    check("single_count1", 32'(cnt2), 32'd1);
    tick;
    #1 check("single_dor", 32'(dor2), 32'd1);
    check("single_data", dout2, 32'h11);
    tick;
    #1 check("single_count0", 32'(cnt2), 32'd0);
    check("single_xfer", xc2, 32'd1);
    check("single_dor_gone", 32'(dor2), 32'd0);

    // back-to-back stream 1..8; word k appears in iteration k+1
    for (int unsigned c = 0; c < 12; c++) begin
      if (c < 8) begin
        dir2 = 1'b1; din2 = 32'(c + 1);
      end else begin
        dir2 = 1'b0;
      end
      #1;
      if (c < 8) check("stream_ack", 32'(af2), 32'd1);
      if (c >= 2 && c <= 9) begin
        check("stream_dor", 32'(dor2), 32'd1);
        check("stream_data", dout2, 32'(c - 1));
      end else begin
        check("stream_idle", 32'(dor2), 32'd0);
      end
      tick;
    end
    #1 check("stream_count", 32'(cnt2), 32'd0);
    check("stream_xfer", xc2, 32'd9);

    // stall until full, then simultaneous in/out
    ack2 = 1'b0; dir2 = 1'b1; din2 = 32'hA;
    #1 check("stall_ack_a", 32'(af2), 32'd1);
    tick; din2 = 32'hB;
    #1 check("stall_ack_b", 32'(af2), 32'd1);
    tick; din2 = 32'hEE;
    #1 check("stall_full", 32'(ful2), 32'd1);
    check("stall_ack_low", 32'(af2), 32'd0);
    check("stall_dor", 32'(dor2), 32'd1);
    check("stall_data", dout2, 32'hA);
    check("stall_count", 32'(cnt2), 32'd2);
    tick;
    #1 check("stall_hold", dout2, 32'hA);
    check("stall_count_hold", 32'(cnt2), 32'd2);
    ack2 = 1'b1; din2 = 32'hC;
    #1 check("pass_ack", 32'(af2), 32'd1);
    tick; dir2 = 1'b0;
    #1 check("pass_count", 32'(cnt2), 32'd2);
    check("pass_data_b", dout2, 32'hB);
    check("pass_xfer", xc2, 32'd10);
    tick;
    #1 check("pass_data_c", dout2, 32'hC);
    check("pass_count1", 32'(cnt2), 32'd1);
    tick;
    #1 check("drain_count", 32'(cnt2), 32'd0);
    check("drain_xfer", xc2, 32'd12);

    // flush a full pipeline
    ack2 = 1'b0; dir2 = 1'b1; din2 = 32'h21;
    tick; din2 = 32'h22;
    tick;
    fl2 = 1'b1; ack2 = 1'b1; din2 = 32'h55;
    #1 check("flush_dor", 32'(dor2), 32'd0);
    check("flush_ack", 32'(af2), 32'd0);
    tick; fl2 = 1'b0; dir2 = 1'b0;
    #1 check("flush_count", 32'(cnt2), 32'd0);
    check("flush_empty", 32'(emp2), 32'd1);
    check("flush_dor_after", 32'(dor2), 32'd0);
    check("flush_xfer", xc2, 32'd12);
    tick;
    #1 check("flush_no_accept", 32'(cnt2), 32'd0);

    // reset while full with DIR high
    ack2 = 1'b0; dir2 = 1'b1; din2 = 32'h31;
    tick; din2 = 32'h32;
    tick;
    #1 check("prereset_full", 32'(ful2), 32'd1);
    rst2 = 1'b1; ack2 = 1'b1; din2 = 32'h77;
    tick; rst2 = 1'b0; dir2 = 1'b0;
    #1 check("mreset_count", 32'(cnt2), 32'd0);
    check("mreset_dor", 32'(dor2), 32'd0);
    check("mreset_xfer", xc2, 32'd0);
    check("mreset_empty", 32'(emp2), 32'd1);
    tick;
    #1 check("mreset_no_accept", 32'(cnt2), 32'd0);
    check("mreset_dor2", 32'(dor2), 32'd0);

    // random handshakes on DEPTH=1 and DEPTH=5
    r_rst = 1'b0;
    for (int unsigned m = 0; m < 2; m++) begin
      mocc[m] = 0;
      mxc[m]  = '0;
    end
    for (int unsigned cyc = 0; cyc < 10000; cyc++) begin
      for (int unsigned m = 0; m < 2; m++) begin
        rdir[m] = ($urandom_range(0, 3) != 0);
        rack[m] = ($urandom_range(0, 2) != 0);
        rfl[m]  = ($urandom_range(0, 63) == 0);
        rdin[m] = $urandom;
      end
      #1;
      for (int unsigned m = 0; m < 2; m++) begin
        logic e_af, e_dor;
        int unsigned cnt_v;
        cnt_v = (m == 0) ? 32'(cnt1) : 32'(cnt5);
        e_af  = !rfl[m] && ((mocc[m] < 32'(dep[m])) || rack[m]);
        e_dor = !rfl[m] && (mocc[m] > 0) && (mpos[m][0] == dep[m] - 1);
        check("rnd_ack",   32'(raf[m]),  32'(e_af));
        check("rnd_dor",   32'(rdor[m]), 32'(e_dor));
        if (e_dor) check("rnd_data", rdout[m], mdat[m][0]);
        check("rnd_count", cnt_v,         mocc[m]);
        check("rnd_empty", 32'(remp[m]), 32'(mocc[m] == 0));
        check("rnd_full",  32'(rful[m]), 32'(mocc[m] == 32'(dep[m])));
        check("rnd_xfer",  rxc[m],        mxc[m]);
        in_x[m]  = e_af && rdir[m];
        out_x[m] = e_dor && rack[m];
      end
      @(posedge clk);
      for (int unsigned m = 0; m < 2; m++) begin
        if (rfl[m]) begin
          mocc[m] = 0;
        end else begin
          int ahead, np;
          if (out_x[m]) begin
            for (int unsigned k = 0; k + 1 < mocc[m]; k++) begin
              mdat[m][k] = mdat[m][k+1];
              mpos[m][k] = mpos[m][k+1];
            end
            mocc[m]--;
            if (mxc[m] != 32'hFFFF_FFFF) mxc[m]++;
          end
          // each word moves one stage unless blocked by the word ahead
          ahead = dep[m];
          for (int unsigned k = 0; k < mocc[m]; k++) begin
            np = mpos[m][k] + 1;
            if (np > ahead - 1) np = ahead - 1;
            mpos[m][k] = np;
            ahead = np;
          end
          if (in_x[m]) begin
            mdat[m][mocc[m]] = rdin[m];
            mpos[m][mocc[m]] = 0;
            mocc[m]++;
          end
        end
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
